// File: rtl/mips_pkg.sv
// Shared loader definitions: imem geometry and the loader FSM state encoding.
package mips_pkg;
  localparam int IMEM_DEPTH = 1024;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int CNT_W      = 11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMMIT, S_RUN, S_ERR
  } ldr_state_t;
endpackage

// File: rtl/imem_port_mux.sv
// imem address/write-enable arbitration between the loader write path and core fetch.
module imem_port_mux
  import mips_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic          sel_ldr,
  input  logic [AW-1:0] ldr_addr,
  input  logic          ldr_we,
  input  logic [AW-1:0] core_pc,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we
);
  assign mem_addr = sel_ldr ? ldr_addr : core_pc;
  assign mem_we   = ldr_we;
endmodule

// File: rtl/imem_loader.sv
// Instruction memory boot/reload controller: streams words into imem from BASE
// and holds the core in reset until the image is committed.
module imem_loader
  import mips_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = ADDR_W,
  parameter int DW    = DATA_W,
  parameter int BASE  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic [AW-1:0] core_pc,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic          core_hold,
  output logic          done,
  output logic          err_ovf,
  output logic [10:0]   word_cnt
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  ldr_state_t       state;
  logic [AW-1:0]    wr_addr;
  logic             wr_we;
  logic             accept;
  logic             sel_ldr;
  logic [CNT_W-1:0] cnt_nxt;

  assign accept  = ld_valid & ld_ready;
  assign cnt_nxt = word_cnt + 1'b1;
  // The overflowing beat still lands in ERR's first cycle, so the write address
  // must stay on the port for any pending write, not just in LOAD/COMMIT.
  assign sel_ldr = (state == S_LOAD) | (state == S_COMMIT) | wr_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ld_ready  <= 1'b0;
      wr_we     <= 1'b0;
      wr_addr   <= AW'(BASE);
      mem_wdata <= '0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      err_ovf   <= 1'b0;
      word_cnt  <= '0;
    end else begin
      wr_we <= 1'b0;
      case (state)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) begin
            state     <= S_LOAD;
            word_cnt  <= '0;
            done      <= 1'b0;
            err_ovf   <= 1'b0;
            core_hold <= 1'b1;
            ld_ready  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            wr_we     <= 1'b1;
            mem_wdata <= ld_data;
            wr_addr   <= AW'(BASE) + AW'(word_cnt);
            word_cnt  <= cnt_nxt;
            // ld_last wins over the depth limit so an exact-fit image commits
            if (ld_last) begin
              state    <= S_COMMIT;
              ld_ready <= 1'b0;
            end else if (cnt_nxt == DEPTH_C) begin
              state    <= S_ERR;
              ld_ready <= 1'b0;
              err_ovf  <= 1'b1;
            end
          end
        end
        S_COMMIT: begin
          state     <= S_RUN;
          core_hold <= 1'b0;
          done      <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  imem_port_mux #(.AW(AW)) u_mux (
    .sel_ldr  (sel_ldr),
    .ldr_addr (wr_addr),
    .ldr_we   (wr_we),
    .core_pc  (core_pc),
    .mem_addr (mem_addr),
    .mem_we   (mem_we)
  );
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a queue model of the expected image checks
// every imem write for address, data and one-cycle latency.
module tb_imem_loader;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BASE  = 0;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic          ld_valid = 1'b0, ld_last = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic [AW-1:0] core_pc = '0;
  logic          ld_ready, mem_we, core_hold, done, err_ovf;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [10:0]   word_cnt;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int            acc_q[$];
  int            wc_q[$];
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  logic [DW-1:0] exp_q[$];

  imem_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .core_pc(core_pc), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .core_hold(core_hold), .done(done),
    .err_ovf(err_ovf), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Record accepted beats (cycle stamp) and observed writes (stamp, addr, data).
  always @(posedge clk) begin
    if (ld_valid && ld_ready) acc_q.push_back(cyc);
    cyc <= cyc + 1;
  end
  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wc_q.push_back(cyc);
    end
  end

  task automatic clear_q();
    acc_q.delete(); wc_q.delete(); wa_q.delete(); wd_q.delete(); exp_q.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive one beat and hold it until accepted; returns at the negedge after acceptance.
  task automatic send(input logic [DW-1:0] d, input logic last);
    int t = 0;
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    while (ld_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout ld_ready=%0b required=1 within 50 cycles", ld_ready);
    end else begin
      exp_q.push_back(d);
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({ld_ready, mem_we, core_hold, done, err_ovf} !== 5'b00100 || word_cnt !== 11'd0 || mem_wdata !== '0) begin
      n_err++;
      $display("FAIL reset_vals rdy/we/hold/done/ovf=%b cnt=%0d wdata=%h required=00100 0 0",
               {ld_ready, mem_we, core_hold, done, err_ovf}, word_cnt, mem_wdata);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    core_pc = $urandom;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (core_hold !== 1'b1 || ld_ready !== 1'b0 || mem_addr !== core_pc) begin
      n_err++;
      $display("FAIL idle_state hold=%0b rdy=%0b addr=%h required hold=1 rdy=0 addr=%h",
               core_hold, ld_ready, mem_addr, core_pc);
    end
  endtask

  task automatic test_load4();
    logic [DW-1:0] img[4];
    img[0] = 32'h20080005; img[1] = 32'h20090003; img[2] = 32'h01095020; img[3] = 32'hAC0A0000;
    clear_q();
    do_start();
    for (int i = 0; i < 4; i++) send(img[i], i == 3);
    n_cmp++;
    if (ld_ready !== 1'b0 || done !== 1'b0 || core_hold !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(BASE + 3)) begin
      n_err++;
      $display("FAIL load4_commit rdy=%0b done=%0b hold=%0b we=%0b addr=%h required 0 0 1 1 %h",
               ld_ready, done, core_hold, mem_we, mem_addr, AW'(BASE + 3));
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || core_hold !== 1'b0 || word_cnt !== 11'd4 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL load4_run done=%0b hold=%0b cnt=%0d we=%0b required 1 0 4 0",
               done, core_hold, word_cnt, mem_we);
    end
    n_cmp++;
    if (wa_q.size() != 4) begin
      n_err++;
      $display("FAIL load4_nwrites got=%0d required=4", wa_q.size());
    end
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      n_cmp++;
      if (wa_q[i] !== AW'(BASE + i) || wd_q[i] !== exp_q[i] || wc_q[i] !== acc_q[i] + 1 || wc_q[i] !== wc_q[0] + i) begin
        n_err++;
        $display("FAIL load4_wr%0d addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                 i, wa_q[i], wd_q[i], wc_q[i], AW'(BASE + i), exp_q[i], acc_q[i] + 1);
      end
    end
    for (int k = 0; k < 4; k++) begin
      core_pc = $urandom;
      #1;
      n_cmp++;
      if (mem_addr !== core_pc || mem_we !== 1'b0) begin
        n_err++;
        $display("FAIL run_pc_track addr=%h we=%0b required addr=%h we=0", mem_addr, mem_we, core_pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_gaps();
    int len;
    len = $urandom_range(4, DEPTH);
    clear_q();
    do_start();
    for (int i = 0; i < len; i++) begin
      send($urandom, i == len - 1);
      if (i == len / 2 - 1) repeat (3) @(negedge clk);
      else if (i < len - 1 && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wa_q.size() != len || done !== 1'b1) begin
      n_err++;
      $display("FAIL gaps_nwrites got=%0d done=%0b required=%0d done=1", wa_q.size(), done, len);
    end
    for (int i = 0; i < len && i < wa_q.size(); i++) begin
      n_cmp++;
      if (wa_q[i] !== AW'(BASE + i) || wd_q[i] !== exp_q[i] || wc_q[i] !== acc_q[i] + 1) begin
        n_err++;
        $display("FAIL gaps_wr%0d addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                 i, wa_q[i], wd_q[i], wc_q[i], AW'(BASE + i), exp_q[i], acc_q[i] + 1);
      end
    end
  endtask

  task automatic test_overflow();
    clear_q();
    do_start();
    for (int i = 0; i < DEPTH; i++) send($urandom, 1'b0);
    n_cmp++;
    if (err_ovf !== 1'b1 || ld_ready !== 1'b0 || core_hold !== 1'b1 || done !== 1'b0 || word_cnt !== 11'(DEPTH)) begin
      n_err++;
      $display("FAIL ovf_state ovf=%0b rdy=%0b hold=%0b done=%0b cnt=%0d required 1 0 1 0 %0d",
               err_ovf, ld_ready, core_hold, done, word_cnt, DEPTH);
    end
    ld_valid = 1'b1; ld_data = $urandom;
    repeat (3) @(negedge clk);
    ld_valid = 1'b0;
    n_cmp++;
    if (wa_q.size() != DEPTH || acc_q.size() != DEPTH) begin
      n_err++;
      $display("FAIL ovf_nwrites writes=%0d accepts=%0d required=%0d", wa_q.size(), acc_q.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < wa_q.size(); i++) begin
      n_cmp++;
      if (wa_q[i] !== AW'(BASE + i) || wd_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL ovf_wr%0d addr=%h data=%h required addr=%h data=%h",
                 i, wa_q[i], wd_q[i], AW'(BASE + i), exp_q[i]);
      end
    end
    do_start();
    n_cmp++;
    if (err_ovf !== 1'b0 || word_cnt !== 11'd0 || ld_ready !== 1'b1 || core_hold !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_restart ovf=%0b cnt=%0d rdy=%0b hold=%0b required 0 0 1 1",
               err_ovf, word_cnt, ld_ready, core_hold);
    end
  endtask

  // Continues from the LOAD entered at the end of test_overflow.
  task automatic test_exact_fit();
    clear_q();
    for (int i = 0; i < DEPTH; i++) send($urandom, i == DEPTH - 1);
    n_cmp++;
    if (err_ovf !== 1'b0 || ld_ready !== 1'b0 || done !== 1'b0 || mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL fit_commit ovf=%0b rdy=%0b done=%0b we=%0b required 0 0 0 1", err_ovf, ld_ready, done, mem_we);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || err_ovf !== 1'b0 || core_hold !== 1'b0 || word_cnt !== 11'(DEPTH)) begin
      n_err++;
      $display("FAIL fit_run done=%0b ovf=%0b hold=%0b cnt=%0d required 1 0 0 %0d",
               done, err_ovf, core_hold, word_cnt, DEPTH);
    end
    n_cmp++;
    if (wa_q.size() != DEPTH || (wa_q.size() == DEPTH && (wa_q[DEPTH-1] !== AW'(BASE + DEPTH - 1) || wd_q[DEPTH-1] !== exp_q[DEPTH-1]))) begin
      n_err++;
      $display("FAIL fit_writes n=%0d required n=%0d last addr=%h", wa_q.size(), DEPTH, AW'(BASE + DEPTH - 1));
    end
  endtask

  task automatic test_reload();
    core_pc = $urandom;
    do_start();
    n_cmp++;
    if (core_hold !== 1'b1 || done !== 1'b0 || word_cnt !== 11'd0 || ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reload_enter hold=%0b done=%0b cnt=%0d rdy=%0b required 1 0 0 1", core_hold, done, word_cnt, ld_ready);
    end
    clear_q();
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    do_start();
    n_cmp++;
    if (word_cnt !== 11'd2 || ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start_in_load cnt=%0d rdy=%0b required cnt=2 rdy=1", word_cnt, ld_ready);
    end
    send($urandom, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wa_q.size() != 3 || done !== 1'b1) begin
      n_err++;
      $display("FAIL reload_nwrites got=%0d done=%0b required=3 done=1", wa_q.size(), done);
    end
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      n_cmp++;
      if (wa_q[i] !== AW'(BASE + i) || wd_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL reload_wr%0d addr=%h data=%h required addr=%h data=%h",
                 i, wa_q[i], wd_q[i], AW'(BASE + i), exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_start();
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    ld_valid = 1'b1; ld_data = $urandom;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({ld_ready, mem_we, core_hold, done, err_ovf} !== 5'b00100 || word_cnt !== 11'd0 ||
        mem_wdata !== '0 || mem_addr !== core_pc) begin
      n_err++;
      $display("FAIL async_reset rdy/we/hold/done/ovf=%b cnt=%0d wdata=%h addr=%h required=00100 0 0 %h",
               {ld_ready, mem_we, core_hold, done, err_ovf}, word_cnt, mem_wdata, mem_addr, core_pc);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (core_hold !== 1'b1 || ld_ready !== 1'b0 || mem_we !== 1'b0 || word_cnt !== 11'd0) begin
      n_err++;
      $display("FAIL post_reset_idle hold=%0b rdy=%0b we=%0b cnt=%0d required 1 0 0 0",
               core_hold, ld_ready, mem_we, word_cnt);
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load4();
    test_gaps();
    test_overflow();
    test_exact_fit();
    test_reload();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within 200000 time units");
    $fatal(1);
  end
endmodule
